load_store_unit: RTL and testbench

//   Downstream of the ALU: takes the ALU result as an effective address and performs byte/half/word loads and stores over a req/gnt/rvalid data bus.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-bus signals of the load/store unit.
// master = the LSU (drives the bus), slave = core plus memory environment.
interface load_store_unit_if;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_fault;
  logic        lsu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    output lsu_rdata, lsu_done, lsu_fault, lsu_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    input  lsu_rdata, lsu_done, lsu_fault, lsu_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store sequencer between a single-cycle core and a req/gnt/rvalid bus.
//   state  | meaning
//   IDLE   | waiting for lsu_valid; decodes and faults bad ops without touching the bus
//   REQ    | mem_req high, address/data/strobes held until mem_gnt
//   WAIT   | waiting for mem_rvalid, timeout counter running
//   RESP   | one-cycle lsu_done (and lsu_fault), core released
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [7:0] CTR_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_ctr;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic        r_fault;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_fault;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Stores only exist for widths 000..010; 011 and 11x are illegal for both.
  always_comb begin
    w_illegal    = (bus.lsu_funct3 == 3'b011) || (bus.lsu_funct3[2:1] == 2'b11) ||
                   (bus.lsu_we && bus.lsu_funct3[2]);
    w_misaligned = ((bus.lsu_funct3[1:0] == 2'b01) && bus.lsu_addr[0]) ||
                   ((bus.lsu_funct3[1:0] == 2'b10) && (bus.lsu_addr[1:0] != 2'b00));
    w_fault      = w_illegal || w_misaligned;
  end

  always_comb begin
    w_wdata = '0;
    w_wstrb = '0;
    if (bus.lsu_we) begin
      case (bus.lsu_funct3[1:0])
        2'b00: begin
          w_wdata = {4{bus.lsu_wdata[7:0]}};
          w_wstrb = 4'b0001 << bus.lsu_addr[1:0];
        end
        2'b01: begin
          w_wdata = {2{bus.lsu_wdata[15:0]}};
          w_wstrb = 4'b0011 << bus.lsu_addr[1:0];
        end
        default: begin
          w_wdata = bus.lsu_wdata;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = bus.mem_rdata[{r_off, 3'b000} +: 8];
    w_half = bus.mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ctr    <= '0;
      r_off    <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_fault  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.lsu_valid) begin
            if (w_fault) begin
              r_fault <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_fault  <= 1'b0;
              r_off    <= bus.lsu_addr[1:0];
              r_funct3 <= bus.lsu_funct3;
              r_we     <= bus.lsu_we;
              r_addr   <= {bus.lsu_addr[31:2], 2'b00};
              r_wdata  <= w_wdata;
              r_wstrb  <= w_wstrb;
              r_state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            r_ctr   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response on the last counted cycle still wins over the timeout.
          if (bus.mem_rvalid) begin
            if (!r_we) r_rdata <= w_load;
            r_state <= S_RESP;
          end else if (r_ctr == CTR_LAST) begin
            r_fault <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_ctr <= r_ctr + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.lsu_rdata = r_rdata;
  assign bus.lsu_done  = (r_state == S_RESP);
  assign bus.lsu_fault = (r_state == S_RESP) && r_fault;
  assign bus.lsu_stall = bus.lsu_valid && (r_state != S_RESP);
  assign bus.mem_req   = (r_state == S_REQ);
  assign bus.mem_we    = (r_state == S_REQ) && r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = (r_state == S_REQ) ? r_wstrb : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_rdata;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One core op against a modelled memory that grants after gnt_dly extra
  // cycles and answers rv_dly cycles into WAIT (never, if rv_dly >= TO).
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word,
                       input int gnt_dly, input int rv_dly, input logic late_rv);
    int          sz, lane, cyc, nreq, nwait, exp_cyc;
    logic        dec_fault, to_fault, granted, got_done;
    logic [31:0] e_addr, e_wdata, v;
    logic [3:0]  e_strb;

    sz        = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lane      = int'(addr % 4);
    dec_fault = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 > 3'd2) || ((lane % sz) != 0);
    to_fault  = !dec_fault && (rv_dly >= TO);
    exp_cyc   = dec_fault ? 1 : to_fault ? gnt_dly + 2 + TO : gnt_dly + rv_dly + 3;
    e_addr    = addr - (addr % 4);
    e_wdata   = 32'h0;
    e_strb    = 4'h0;
    if (we) begin
      if (sz == 1) begin
        e_wdata = (wdata % 256) * 32'h0101_0101;
        e_strb  = 4'(1 << lane);
      end else if (sz == 2) begin
        e_wdata = (wdata % 65536) * 32'h0001_0001;
        e_strb  = 4'(3 << lane);
      end else begin
        e_wdata = wdata;
        e_strb  = 4'hF;
      end
    end
    if (sz == 1) begin
      v = (word >> (8 * lane)) % 256;
      if (f3 < 3'd4 && v >= 128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = (word >> (16 * (lane / 2))) % 65536;
      if (f3 < 3'd4 && v >= 32768) v = v - 32'd65536;
    end else begin
      v = word;
    end

    bus.lsu_valid  = 1'b1;
    bus.lsu_we     = we;
    bus.lsu_funct3 = f3;
    bus.lsu_addr   = addr;
    bus.lsu_wdata  = wdata;
    cyc = 0; nreq = 0; nwait = 0; granted = 1'b0; got_done = 1'b0;
    while (!got_done && cyc <= exp_cyc + TO + 8) begin
      #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (bus.lsu_done) begin
        got_done = 1'b1;
        if (!we && !dec_fault && !to_fault) exp_rdata = v;
        chk("done_cycle", cyc, exp_cyc);
        chk("fault", bus.lsu_fault, dec_fault || to_fault);
        chk("rdata", bus.lsu_rdata, exp_rdata);
        chk("stall_resp", bus.lsu_stall, 1'b0);
        chk("req_cycles", nreq, dec_fault ? 0 : gnt_dly + 1);
        bus.lsu_valid  = 1'b0;
        bus.mem_rvalid = late_rv;
      end else begin
        chk("stall", bus.lsu_stall, 1'b1);
        if (granted) begin
          if (nwait == rv_dly) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = word;
          end else begin
            bus.mem_gnt = ($urandom_range(0, 3) == 0);
          end
          nwait++;
        end else if (bus.mem_req) begin
          chk("mem_addr", bus.mem_addr, e_addr);
          chk("mem_we", bus.mem_we, we);
          chk("mem_wstrb", bus.mem_wstrb, e_strb);
          if (we) chk("mem_wdata", bus.mem_wdata, e_wdata);
          nreq++;
          bus.mem_rvalid = ($urandom_range(0, 1) == 1);
          if (nreq > gnt_dly) begin
            bus.mem_gnt = 1'b1;
            granted     = 1'b1;
          end
        end else begin
          bus.mem_rvalid = ($urandom_range(0, 1) == 1);
          bus.mem_gnt    = ($urandom_range(0, 1) == 1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!got_done) begin
      chk("done_seen", 1'b0, 1'b1);
      bus.lsu_valid = 1'b0;
    end
    #1;
    chk("done_pulse", bus.lsu_done, 1'b0);
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
  endtask

  initial begin
    int r, gd, rd;
    n_vec = 0;
    n_err = 0;
    exp_rdata = 32'h0;
    rst_n = 1'b0;
    bus.lsu_valid = 1'b0; bus.lsu_we = 1'b0; bus.lsu_funct3 = 3'b0;
    bus.lsu_addr = '0; bus.lsu_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("rst_done", bus.lsu_done, 1'b0);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_rdata", bus.lsu_rdata, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);

    do_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, 0, 1'b0);
    do_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 1, 1'b0);
    do_op(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 3, 0, 1'b0);
    do_op(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0, TO + 5, 1'b1);
    do_op(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h0BAD_F00D, 1, TO - 1, 1'b0);
    do_op(1'b0, 3'b001, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 0, 0, 1'b0);

    // Reset while waiting for a response abandons the access.
    bus.lsu_valid = 1'b1; bus.lsu_we = 1'b0; bus.lsu_funct3 = 3'b010;
    bus.lsu_addr = 32'h20; bus.lsu_wdata = '0;
    @(negedge clk);
    #1;
    chk("rst6_req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.mem_rvalid = 1'b1;
    #1;
    exp_rdata = 32'h0;
    chk("rst6_done", bus.lsu_done, 1'b0);
    chk("rst6_fault", bus.lsu_fault, 1'b0);
    chk("rst6_stall", bus.lsu_stall, 1'b0);
    chk("rst6_req0", bus.mem_req, 1'b0);
    chk("rst6_wstrb", bus.mem_wstrb, 4'h0);
    chk("rst6_rdata", bus.lsu_rdata, exp_rdata);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst6_stale", bus.lsu_done, 1'b0);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    do_op(1'b1, 3'b010, 32'h0000_0010, 32'hA5A5_0F0F, 32'h0, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      gd = $urandom_range(0, 3);
      rd = (r < 7) ? r % 4 : (r == 7) ? TO - 1 : TO + 2;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, gd, rd, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
